// File: rtl/uc_beh_if.sv
// uc_beh_if: control/data bundle for the uc_beh up/down counter.
// The master side drives the counter controls and observes q/tc;
// the slave side is the counter itself. Clock and clear stay scalar ports.
interface uc_beh_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic             up_down;
  logic             en;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q;
  logic             tc;

  modport master (
    output load, up_down, en, data,
    input  q, tc
  );

  modport slave (
    input  load, up_down, en, data,
    output q, tc
  );
endinterface

// File: rtl/uc_beh.sv
// uc_beh: synchronous up/down universal counter with parallel load,
// count enable and combinational terminal-count flag.
//
// Priority at each rising edge: clr, then load, then count (en).
// clr doubles as the synchronous active-high reset; q is undefined
// until the first edge with clr high.
//
// Build option UC_BEH_SATURATE_EN: when defined, counting up at all-ones
// holds all-ones and counting down at zero holds zero. When undefined
// (default), the counter wraps modulo 2^WIDTH. tc, clr and load behave
// the same in both builds.
module uc_beh #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        clr,
  uc_beh_if.slave     bus
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_r;
  logic             at_max;
  logic             at_min;

  // Boundary detection shared by the count path and the tc flag.
  always_comb begin
    at_max = (q_r == ALL_ONES);
    at_min = (q_r == ZERO);
  end

  // Counter register: clear, then load, then enabled up/down count.
  always_ff @(posedge clk) begin
    if (clr) begin
      q_r <= ZERO;
    end else if (bus.load) begin
      q_r <= bus.data;
    end else if (bus.en) begin
      if (bus.up_down) begin
`ifdef UC_BEH_SATURATE_EN
        if (!at_max) q_r <= q_r + ONE;
`else
        q_r <= q_r + ONE;
`endif
      end else begin
`ifdef UC_BEH_SATURATE_EN
        if (!at_min) q_r <= q_r - ONE;
`else
        q_r <= q_r - ONE;
`endif
      end
    end
  end

  assign bus.q = q_r;

  // Terminal count: asserted only when the next edge would count past the
  // boundary in the selected direction, so a cascaded stage can use it as en.
  assign bus.tc = bus.en & ~bus.load & ~clr &
                  (bus.up_down ? at_max : at_min);

endmodule

// File: tb/tb_uc_beh.sv
// tb_uc_beh: directed self-checking bench for uc_beh (WIDTH = 4).
// Expected values are hand-computed constants; the wrap cases select the
// saturating expectation when UC_BEH_SATURATE_EN is defined.
module tb_uc_beh;

  localparam int WIDTH = 4;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_err;

  uc_beh_if #(.WIDTH(WIDTH)) bus ();

  uc_beh #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // Clock and initial values.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are changed and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic ld, input logic ud,
                       input logic e, input logic [WIDTH-1:0] d);
    clr         = c;
    bus.load    = ld;
    bus.up_down = ud;
    bus.en      = e;
    bus.data    = d;
  endtask

  logic [WIDTH-1:0] up_seq [4];
  logic [WIDTH-1:0] dn_seq [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    up_seq = '{4'hB, 4'hC, 4'hD, 4'hE};
    dn_seq = '{4'hD, 4'hC, 4'hB, 4'hA};

    // Reset
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
    tick();
    check("reset_q", 32'(bus.q), 32'h0);
    check("reset_tc", 32'(bus.tc), 32'h0);

    // Load A, then hold
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'hA);
    tick();
    check("load_a", 32'(bus.q), 32'hA);
    bus.load = 1'b0;
    tick();
    check("load_hold", 32'(bus.q), 32'hA);

    // Count up four edges
    bus.en = 1'b1;
    bus.up_down = 1'b1;
    #1;
    check("tc_mid_up", 32'(bus.tc), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("up_%0d", i), 32'(bus.q), 32'(up_seq[i]));
    end

    // Direction change takes effect on the very next edge
    bus.up_down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("down_%0d", i), 32'(bus.q), 32'(dn_seq[i]));
    end

    // Hold with en low
    bus.en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("hold_%0d", i), 32'(bus.q), 32'hA);
    end

    // Clear, then stay at zero with en low
    clr = 1'b1;
    tick();
    check("clear", 32'(bus.q), 32'h0);
    clr = 1'b0;
    tick();
    check("clear_hold", 32'(bus.q), 32'h0);
    check("tc_en_low", 32'(bus.tc), 32'h0);

    // Up wrap at all-ones
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'hF);
    #1;
    check("tc_load_mask", 32'(bus.tc), 32'h0);
    tick();
    check("load_f", 32'(bus.q), 32'hF);
    bus.load = 1'b0;
    #1;
    check("tc_up_max", 32'(bus.tc), 32'h1);
    tick();
`ifdef UC_BEH_SATURATE_EN
    check("up_wrap", 32'(bus.q), 32'hF);
    check("tc_after_up_wrap", 32'(bus.tc), 32'h1);
`else
    check("up_wrap", 32'(bus.q), 32'h0);
    check("tc_after_up_wrap", 32'(bus.tc), 32'h0);
`endif

    // Down wrap at zero
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    tick();
    check("load_0", 32'(bus.q), 32'h0);
    bus.load = 1'b0;
    bus.en = 1'b1;
    #1;
    check("tc_down_min", 32'(bus.tc), 32'h1);
    bus.up_down = 1'b1;
    #1;
    check("tc_up_at_zero", 32'(bus.tc), 32'h0);
    bus.up_down = 1'b0;
    clr = 1'b1;
    #1;
    check("tc_clr_mask", 32'(bus.tc), 32'h0);
    clr = 1'b0;
    tick();
`ifdef UC_BEH_SATURATE_EN
    check("down_wrap", 32'(bus.q), 32'h0);
`else
    check("down_wrap", 32'(bus.q), 32'hF);
`endif

    // Priority: clr beats load and en
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'h7);
    tick();
    check("prio_clr_load", 32'(bus.q), 32'h0);

    // Priority: load beats en, counting resumes next edge
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h7);
    tick();
    check("prio_load_en", 32'(bus.q), 32'h7);
    bus.load = 1'b0;
    tick();
    check("count_after_load", 32'(bus.q), 32'h8);
    bus.up_down = 1'b0;
    tick();
    check("down_after_up", 32'(bus.q), 32'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
